// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock, and issues the
// reset for the PLL output domain. It retries on a lock timeout and faults after repeated failures.
module pll_lock_supervisor #(
  parameter int RESET_HOLD    = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       locked_in,
  input  logic       clear_counts,
  output logic       pll_resetb,
  output logic       rst_out_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int MAX_AB  = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          sync1, locked_s;
  logic          retry_evt, loss_evt;
  logic [3:0]    retry_inc;

  // locked_in comes from the PLL with no timing relationship to clock_in.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
    end
  end

  assign retry_inc = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    retry_evt  = 1'b0;
    loss_evt   = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == CW'(RESET_HOLD - 1)) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_evt  = 1'b1;
          state_next = (int'(retry_inc) >= MAX_RETRIES) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (!locked_s)                            state_next = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1))   state_next = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_next = PLL_RST;
          loss_evt   = 1'b1;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = PLL_RST;
    endcase
  end

  // The shared counter restarts on every state change; it idles in RUN and FAULT.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state <= PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (state == PLL_RST || state == WAIT_LOCK || state == STABLE)
        cnt <= cnt + CW'(1);
    end
  end

  // clear_counts wins over any increment landing on the same edge.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
    end else begin
      if (clear_counts)
        retry_count <= 4'd0;
      else if (state_next == RUN && state != RUN)
        retry_count <= 4'd0;
      else if (retry_evt)
        retry_count <= retry_inc;

      if (clear_counts)
        loss_count <= 8'd0;
      else if (loss_evt && loss_count != 8'hFF)
        loss_count <= loss_count + 8'd1;
    end
  end

  assign pll_resetb = (state != PLL_RST);
  assign ready      = (state == RUN);
  assign rst_out_n  = (state == RUN);
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a vector table for bring-up, loss and
// glitch behaviour, plus sequences for timeout/fault, saturation, clear and async reset.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       resetn, locked_in, clear_counts;
  logic       pll_resetb, rst_out_n, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RESET_HOLD(8), .LOCK_TIMEOUT(100), .STABLE_CYCLES(16), .MAX_RETRIES(3)
  ) dut (
    .clock_in(clk), .resetn(resetn), .locked_in(locked_in), .clear_counts(clear_counts),
    .pll_resetb(pll_resetb), .rst_out_n(rst_out_n), .ready(ready), .fault(fault),
    .retry_count(retry_count), .loss_count(loss_count)
  );

  typedef struct {
    logic  rstn;
    logic  lock;
    logic  clr;
    int    ticks;
    logic  each;
    int    e_pllrb;
    int    e_ready;
    int    e_fault;
    int    e_retry;
    int    e_loss;
    string name;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic rstn, input logic lock, input int ticks,
                              input logic each, input int pllrb, input int rdy,
                              input int e_loss, input string name);
    vec_t v;
    v.rstn = rstn; v.lock = lock; v.clr = 1'b0; v.ticks = ticks; v.each = each;
    v.e_pllrb = pllrb; v.e_ready = rdy; v.e_fault = 0; v.e_retry = 0;
    v.e_loss = e_loss; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, ".pll_resetb"},  int'(pll_resetb),  v.e_pllrb);
    check({v.name, ".ready"},       int'(ready),       v.e_ready);
    check({v.name, ".rst_out_n"},   int'(rst_out_n),   v.e_ready);
    check({v.name, ".fault"},       int'(fault),       v.e_fault);
    check({v.name, ".retry_count"}, int'(retry_count), v.e_retry);
    check({v.name, ".loss_count"},  int'(loss_count),  v.e_loss);
  endtask

  task automatic wait_ready(input logic val, input string name);
    int n = 0;
    while (ready !== val && n < 300) begin
      tick();
      n++;
    end
    check(name, int'(ready), int'(val));
  endtask

  initial begin
    resetn       = 1'b0;
    locked_in    = 1'b0;
    clear_counts = 1'b0;

    // Edge numbering: edge k is the k-th rising edge after resetn release.
    vecs[0]  = mk(0, 0,  3, 0, 0, 0, 0, "in_reset");
    vecs[1]  = mk(1, 0,  0, 0, 0, 0, 0, "release_cycle0");
    vecs[2]  = mk(1, 0,  7, 1, 0, 0, 0, "pll_rst_hold");
    vecs[3]  = mk(1, 0,  1, 0, 1, 0, 0, "wait_lock_entry");
    vecs[4]  = mk(1, 0, 12, 1, 1, 0, 0, "wait_no_lock");
    vecs[5]  = mk(1, 1, 18, 1, 1, 0, 0, "lock_qualify");
    vecs[6]  = mk(1, 1,  1, 0, 1, 1, 0, "run_entry");
    vecs[7]  = mk(1, 0,  2, 1, 1, 1, 0, "loss_sync_delay");
    vecs[8]  = mk(1, 0,  1, 0, 0, 0, 1, "loss_detect");
    vecs[9]  = mk(1, 1,  7, 1, 0, 0, 1, "relock_rst_hold");
    vecs[10] = mk(1, 1,  1, 0, 1, 0, 1, "relock_wait");
    vecs[11] = mk(1, 1, 16, 1, 1, 0, 1, "relock_stable");
    vecs[12] = mk(1, 1,  1, 0, 1, 1, 1, "relock_run");
    vecs[13] = mk(1, 0,  3, 0, 0, 0, 2, "second_loss");
    vecs[14] = mk(1, 0,  8, 0, 1, 0, 2, "unstable_wait");
    vecs[15] = mk(1, 1, 10, 1, 1, 0, 2, "glitch_pre");
    vecs[16] = mk(1, 0,  1, 1, 1, 0, 2, "glitch_low");
    vecs[17] = mk(1, 1, 18, 1, 1, 0, 2, "glitch_recover");
    vecs[18] = mk(1, 1,  1, 0, 1, 1, 2, "glitch_run");

    for (int i = 0; i < NVEC; i++) begin
      resetn       = vecs[i].rstn;
      locked_in    = vecs[i].lock;
      clear_counts = vecs[i].clr;
      if (vecs[i].ticks == 0) #1;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        tick();
        if (vecs[i].each && t != vecs[i].ticks - 1) check_vec(vecs[i]);
      end
      check_vec(vecs[i]);
    end

    // Lock never returns: three timeout rounds of 8 + 100 cycles, then FAULT.
    locked_in = 1'b0;
    repeat (3) tick();
    check("timeout_start.ready", int'(ready), 0);
    check("timeout_start.loss", int'(loss_count), 3);
    for (int r = 1; r <= 3; r++) begin
      repeat (107) tick();
      check($sformatf("round%0d_last_wait.pll_resetb", r), int'(pll_resetb), 1);
      check($sformatf("round%0d_last_wait.retry", r), int'(retry_count), r - 1);
      tick();
      check($sformatf("round%0d_timeout.retry", r), int'(retry_count), r);
      check($sformatf("round%0d_timeout.fault", r), int'(fault), (r == 3) ? 1 : 0);
      check($sformatf("round%0d_timeout.pll_resetb", r), int'(pll_resetb), (r == 3) ? 1 : 0);
    end

    // FAULT ignores lock activity; only clear_counts touches the counters.
    locked_in = 1'b1;
    repeat (50) tick();
    check("fault_hold.fault", int'(fault), 1);
    check("fault_hold.pll_resetb", int'(pll_resetb), 1);
    check("fault_hold.rst_out_n", int'(rst_out_n), 0);
    check("fault_hold.retry", int'(retry_count), 3);
    check("fault_hold.loss", int'(loss_count), 3);
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    check("fault_clear.retry", int'(retry_count), 0);
    check("fault_clear.loss", int'(loss_count), 0);
    check("fault_clear.fault", int'(fault), 1);

    // Reset out of FAULT, one timeout, then lock: retry_count clears on RUN entry.
    resetn = 1'b0;
    #1;
    check("reset_from_fault.fault", int'(fault), 0);
    check("reset_from_fault.pll_resetb", int'(pll_resetb), 0);
    locked_in = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (108) tick();
    check("one_timeout.retry", int'(retry_count), 1);
    check("one_timeout.pll_resetb", int'(pll_resetb), 0);
    locked_in = 1'b1;
    wait_ready(1'b1, "one_timeout.reach_run");
    check("run_entry_retry_clear", int'(retry_count), 0);

    // 260 lock losses saturate loss_count at 255.
    for (int i = 1; i <= 260; i++) begin
      locked_in = 1'b0;
      wait_ready(1'b0, "sat.drop");
      locked_in = 1'b1;
      wait_ready(1'b1, "sat.rise");
      if (i == 1 || i == 255 || i == 256 || i == 260)
        check($sformatf("sat_loss_after_%0d", i), int'(loss_count), (i == 1) ? 1 : 255);
    end

    // clear_counts on the same edge as a loss increment.
    locked_in = 1'b0;
    repeat (2) tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    check("clear_vs_incr.ready", int'(ready), 0);
    check("clear_vs_incr.loss", int'(loss_count), 0);
    locked_in = 1'b1;
    wait_ready(1'b1, "post_clear.run");
    locked_in = 1'b0;
    wait_ready(1'b0, "post_clear.drop");
    check("post_clear.loss", int'(loss_count), 1);
    locked_in = 1'b1;
    wait_ready(1'b1, "async.run");

    // Reset asserted mid-cycle in RUN acts before the next edge.
    #3;
    resetn = 1'b0;
    #1;
    check("async_rst.rst_out_n", int'(rst_out_n), 0);
    check("async_rst.pll_resetb", int'(pll_resetb), 0);
    check("async_rst.ready", int'(ready), 0);
    check("async_rst.retry", int'(retry_count), 0);
    check("async_rst.loss", int'(loss_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 8: number of cycles pll_resetb is held low per PLL reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000: maximum cycles spent in WAIT_LOCK before an attempt fails (>=1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 64: consecutive synchronized-lock cycles required before release (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT (1..15).
REQ-005 SHALL have port clock_in, input, 1: single clock for all logic (PLL reference clock); it is the only clock.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port locked_in, input, 1: PLL LOCK output, asynchronous to clock_in.
REQ-008 SHALL have port clear_counts, input, 1: synchronous pulse that zeroes retry_count and loss_count.
REQ-009 SHALL have port pll_resetb, output, 1: drives PLL RESETB; low means the PLL is held in reset.
REQ-010 SHALL have port rst_out_n, output, 1: active-low reset for logic in the PLL output domain.
REQ-011 SHALL have port ready, output, 1: high only while in RUN.
REQ-012 SHALL have port fault, output, 1: high only while in FAULT.
REQ-013 SHALL have port retry_count, output, 4: number of timed-out lock attempts, saturating.
REQ-014 SHALL have port loss_count, output, 8: number of lock losses seen in RUN, saturating at 255.

Function
REQ-015 SHALL pass locked_in through a 2-flop synchronizer; all decisions use the second-stage output locked_s, giving a sampling latency of 2 cycles.
REQ-016 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT using one shared cycle counter that is cleared on every state change.
REQ-017 SHALL decode all outputs from registered state: pll_resetb = (state != PLL_RST); rst_out_n = ready = (state == RUN); fault = (state == FAULT).
REQ-018 PLL_RST SHALL last exactly RESET_HOLD cycles and then go to WAIT_LOCK.
REQ-019 WAIT_LOCK: if locked_s = 1, SHALL go to STABLE the next cycle; otherwise, after LOCK_TIMEOUT cycles, SHALL increment retry_count.
REQ-020 On a WAIT_LOCK timeout, SHALL go to FAULT if the incremented retry_count >= MAX_RETRIES, and to PLL_RST otherwise.
REQ-021 STABLE: if locked_s = 0 in any cycle, SHALL return to WAIT_LOCK with a fresh timeout; after STABLE_CYCLES consecutive cycles with locked_s = 1, SHALL go to RUN.
REQ-022 RUN: if locked_s = 0, SHALL go to PLL_RST the next cycle and increment loss_count; rst_out_n SHALL deassert in that same transition.
REQ-023 FAULT SHALL be terminal until resetn is asserted: pll_resetb = 1, rst_out_n = 0, lock activity ignored, counters frozen except for clear_counts.
REQ-024 retry_count SHALL reset to 0 on entry to RUN; loss_count SHALL persist across RUN entries.
REQ-025 Both counters SHALL saturate at their maximum value and never wrap.
REQ-026 clear_counts SHALL take priority over a simultaneous increment: the counter reads 0 the next cycle.
REQ-027 A lock glitch shorter than 1 cycle that is missed by the synchronizer SHALL have no effect; any sampled low SHALL be acted on.

Reset
REQ-028 While resetn = 0, SHALL hold: state = PLL_RST with counter 0, sync flops 0, pll_resetb = 0, rst_out_n = 0, ready = 0, fault = 0, retry_count = 0, loss_count = 0.
REQ-029 Reset assertion mid-operation (including in RUN or FAULT) SHALL immediately drive rst_out_n = 0 and pll_resetb = 0, asynchronously.
REQ-030 Reset release SHALL be synchronous, and PLL_RST SHALL start counting on the first clock edge after release.

Verification (RESET_HOLD = 8, LOCK_TIMEOUT = 100, STABLE_CYCLES = 16, MAX_RETRIES = 3)
REQ-031 Normal bring-up: release resetn, raise locked_in at cycle 20 -> pll_resetb low for cycles 0-7; rst_out_n/ready rise exactly 2 + 1 + 16 cycles after locked_in rises; retry_count = 0.
REQ-032 Unstable lock: locked_in high 10 cycles, low 1 cycle, then high -> stays out of RUN until 16 clean cycles; rst_out_n never pulses high.
REQ-033 Lock never arrives: locked_in tied low -> three PLL_RST/WAIT_LOCK rounds; retry_count steps 1, 2, 3; fault = 1 with pll_resetb = 1 and rst_out_n = 0 permanently.
REQ-034 Loss in RUN: drop locked_in while ready = 1 -> rst_out_n falls 3 cycles later; loss_count increments by 1; pll_resetb goes low for 8 cycles; re-lock returns to RUN.
REQ-035 Saturation and clear: 260 lock-loss events -> loss_count = 255; clear_counts pulsed on the same cycle as an increment -> loss_count = 0.
REQ-036 Async reset in RUN: assert resetn between clock edges -> rst_out_n = 0 and pll_resetb = 0 before the next edge; all counters read 0.
